// File: rtl/uart_init_sequencer.sv
// uart_init_sequencer: Wishbone master that configures a 16550-style UART.
// It runs a fixed seven-step register sequence: set DLAB, load the divisor,
// restore the line control, program FIFO and interrupt enables, then read
// the LCR back to confirm the UART took the configuration.
module uart_init_sequencer #(
    parameter int TIMEOUT = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [15:0] divisor_i,
    input  logic [7:0]  lcr_cfg_i,
    input  logic [7:0]  fcr_cfg_i,
    input  logic [7:0]  ier_cfg_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [2:0]  wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] LAST_STEP = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        BUS,
        GAP,
        CHECK,
        FINISH
    } state_t;

    state_t         state_q;
    logic [2:0]     step_q;
    logic [CW-1:0]  tmo_q;
    logic [15:0]    div_q;
    logic [7:0]     lcr_q;
    logic [7:0]     fcr_q;
    logic [7:0]     ier_q;
    logic [7:0]     rdat_q;

    logic           busy_q;
    logic           done_q;
    logic           err_q;
    logic [1:0]     err_code_q;
    logic [2:0]     adr_q;
    logic [7:0]     dat_q;
    logic           we_q;
    logic           stb_q;
    logic           cyc_q;

    logic [2:0]     selStep_d;
    logic [15:0]    selDiv_d;
    logic [7:0]     selLcr_d;
    logic [7:0]     selFcr_d;
    logic [7:0]     selIer_d;
    logic [2:0]     adr_d;
    logic [7:0]     dat_d;
    logic           we_d;

    // Bus fields for the step about to be launched; the first step comes straight
    // from the inputs because the configuration is latched on that same edge.
    always_comb begin
        selStep_d = 3'd0;
        selDiv_d  = divisor_i;
        selLcr_d  = lcr_cfg_i;
        selFcr_d  = fcr_cfg_i;
        selIer_d  = ier_cfg_i;
        if (state_q != IDLE) begin
            selStep_d = step_q + 3'd1;
            selDiv_d  = div_q;
            selLcr_d  = lcr_q;
            selFcr_d  = fcr_q;
            selIer_d  = ier_q;
        end
        adr_d = 3'd0;
        dat_d = 8'h00;
        we_d  = 1'b1;
        case (selStep_d)
            3'd0:    begin adr_d = 3'd3; dat_d = selLcr_d | 8'h80; end
            3'd1:    begin adr_d = 3'd0; dat_d = selDiv_d[7:0];    end
            3'd2:    begin adr_d = 3'd1; dat_d = selDiv_d[15:8];   end
            3'd3:    begin adr_d = 3'd3; dat_d = selLcr_d & 8'h7F; end
            3'd4:    begin adr_d = 3'd2; dat_d = selFcr_d;         end
            3'd5:    begin adr_d = 3'd1; dat_d = selIer_d;         end
            3'd6:    begin adr_d = 3'd3; we_d  = 1'b0;             end
            default: begin we_d = 1'b0;                            end
        endcase
    end

    // Sequencer FSM with every output registered; reset aborts any transaction.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            step_q     <= 3'd0;
            tmo_q      <= '0;
            div_q      <= 16'h0000;
            lcr_q      <= 8'h00;
            fcr_q      <= 8'h00;
            ier_q      <= 8'h00;
            rdat_q     <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            adr_q      <= 3'd0;
            dat_q      <= 8'h00;
            we_q       <= 1'b0;
            stb_q      <= 1'b0;
            cyc_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        div_q      <= divisor_i;
                        lcr_q      <= lcr_cfg_i;
                        fcr_q      <= fcr_cfg_i;
                        ier_q      <= ier_cfg_i;
                        err_q      <= 1'b0;
                        err_code_q <= 2'b00;
                        busy_q     <= 1'b1;
                        step_q     <= 3'd0;
                        tmo_q      <= '0;
                        adr_q      <= adr_d;
                        dat_q      <= dat_d;
                        we_q       <= we_d;
                        stb_q      <= 1'b1;
                        cyc_q      <= 1'b1;
                        state_q    <= BUS;
                    end
                end
                BUS: begin
                    if (wb_ack_i) begin
                        if (step_q == LAST_STEP) begin
                            rdat_q <= wb_dat_i;
                        end
                        adr_q   <= 3'd0;
                        dat_q   <= 8'h00;
                        we_q    <= 1'b0;
                        stb_q   <= 1'b0;
                        cyc_q   <= 1'b0;
                        state_q <= GAP;
                    end else if (tmo_q == CW'(TIMEOUT - 1)) begin
                        adr_q      <= 3'd0;
                        dat_q      <= 8'h00;
                        we_q       <= 1'b0;
                        stb_q      <= 1'b0;
                        cyc_q      <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b01;
                        done_q     <= 1'b1;
                        state_q    <= FINISH;
                    end else begin
                        tmo_q <= tmo_q + CW'(1);
                    end
                end
                GAP: begin
                    if (step_q == LAST_STEP) begin
                        state_q <= CHECK;
                    end else begin
                        step_q  <= step_q + 3'd1;
                        tmo_q   <= '0;
                        adr_q   <= adr_d;
                        dat_q   <= dat_d;
                        we_q    <= we_d;
                        stb_q   <= 1'b1;
                        cyc_q   <= 1'b1;
                        state_q <= BUS;
                    end
                end
                CHECK: begin
                    if (rdat_q != (lcr_q & 8'h7F)) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                    end
                    done_q  <= 1'b1;
                    state_q <= FINISH;
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_we_o    = we_q;
    assign wb_stb_o   = stb_q;
    assign wb_cyc_o   = cyc_q;

endmodule
